// File: rtl/uart_tx_frame.sv
// UART transmit engine: a TX FIFO feeding a 16x-oversampled frame serializer with
// run-time character length, parity mode, stop-bit count and line break.
module uart_tx_frame #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned CW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          baud16_pulse,
    input  logic          wr_en,
    input  logic [8:0]    wr_data,
    input  logic [2:0]    char_len,
    input  logic [2:0]    parity_mode,
    input  logic [1:0]    stop_sel,
    input  logic          break_req,
    output logic          tx,
    output logic          txrdy,
    output logic          fifo_empty,
    output logic [CW-1:0] fifo_count,
    output logic          tx_busy,
    output logic          tx_done,
    output logic          overflow
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [2:0] {
        StIdle, StLoad, StStart, StData, StParity, StStop, StBreak
    } state_e;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // FIFO storage and bookkeeping
    logic [8:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          txrdy_q, fifo_empty_q, overflow_q;
    logic          full, push, pop;
    logic [8:0]    rd_data, rd_masked;

    // Serializer state and per-frame latched configuration
    state_e     state_q, state_d;
    logic [4:0] tick_q, tick_d;
    logic [3:0] bit_idx_q, bit_idx_d;
    logic [8:0] char_q, char_d;
    logic [3:0] last_idx_q, last_idx_d;
    logic       par_en_q, par_en_d;
    logic       par_bit_q, par_bit_d;
    logic [4:0] stop_last_q, stop_last_d;
    logic       tx_q, tx_d;
    logic       tx_busy_q, tx_done_q, done_d;

    // Decoded configuration presented at the moment of the pop
    logic [3:0] ld_last_idx;
    logic       ld_par_en, ld_par_bit;
    logic [4:0] ld_stop_last;

    assign full    = (count_q == CW'(FIFO_DEPTH));
    assign push    = wr_en && !full;
    assign rd_data = mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        ld_last_idx = 4'd7;
        case (char_len)
            3'd0:    ld_last_idx = 4'd4;
            3'd1:    ld_last_idx = 4'd5;
            3'd2:    ld_last_idx = 4'd6;
            3'd4:    ld_last_idx = 4'd8;
            default: ld_last_idx = 4'd7;
        endcase
        rd_masked = '0;
        for (int i = 0; i < 9; i++) begin
            rd_masked[i] = rd_data[i] & (4'(i) <= ld_last_idx);
        end
        ld_par_en  = 1'b0;
        ld_par_bit = 1'b0;
        case (parity_mode)
            3'd1:    begin ld_par_en = 1'b1; ld_par_bit = ~^rd_masked; end
            3'd2:    begin ld_par_en = 1'b1; ld_par_bit = ^rd_masked;  end
            3'd3:    begin ld_par_en = 1'b1; ld_par_bit = 1'b1;        end
            3'd4:    begin ld_par_en = 1'b1; ld_par_bit = 1'b0;        end
            default: ld_par_en = 1'b0;
        endcase
        case (stop_sel)
            2'd0:    ld_stop_last = 5'd15;
            2'd1:    ld_stop_last = 5'd23;
            default: ld_stop_last = 5'd31;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        tick_d      = tick_q;
        bit_idx_d   = bit_idx_q;
        char_d      = char_q;
        last_idx_d  = last_idx_q;
        par_en_d    = par_en_q;
        par_bit_d   = par_bit_q;
        stop_last_d = stop_last_q;
        tx_d        = tx_q;
        done_d      = 1'b0;
        pop         = 1'b0;
        // Free-running tick count; every bit entry below clears it.
        if (baud16_pulse) tick_d = tick_q + 5'd1;
        unique case (state_q)
            StIdle: begin
                tx_d = 1'b1;
                if (break_req) begin
                    state_d = StBreak;
                    tx_d    = 1'b0;
                end else if (!fifo_empty_q) begin
                    state_d     = StLoad;
                    pop         = 1'b1;
                    char_d      = rd_masked;
                    last_idx_d  = ld_last_idx;
                    par_en_d    = ld_par_en;
                    par_bit_d   = ld_par_bit;
                    stop_last_d = ld_stop_last;
                end
            end
            StLoad: begin
                tx_d = 1'b1;
                if (baud16_pulse) begin
                    state_d = StStart;
                    tick_d  = '0;
                    tx_d    = 1'b0;
                end
            end
            StStart: begin
                if (baud16_pulse && tick_q == 5'd15) begin
                    state_d   = StData;
                    tick_d    = '0;
                    bit_idx_d = '0;
                    tx_d      = char_q[0];
                end
            end
            StData: begin
                if (baud16_pulse && tick_q == 5'd15) begin
                    tick_d = '0;
                    if (bit_idx_q == last_idx_q) begin
                        state_d = par_en_q ? StParity : StStop;
                        tx_d    = par_en_q ? par_bit_q : 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                        char_d    = char_q >> 1;
                        tx_d      = char_q[1];
                    end
                end
            end
            StParity: begin
                if (baud16_pulse && tick_q == 5'd15) begin
                    state_d = StStop;
                    tick_d  = '0;
                    tx_d    = 1'b1;
                end
            end
            StStop: begin
                tx_d = 1'b1;
                if (baud16_pulse && tick_q == stop_last_q) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            StBreak: begin
                tx_d = 1'b0;
                if (!break_req && baud16_pulse) begin
                    state_d = StIdle;
                    tx_d    = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            txrdy_q      <= 1'b1;
            fifo_empty_q <= 1'b1;
            overflow_q   <= 1'b0;
            state_q      <= StIdle;
            tick_q       <= '0;
            bit_idx_q    <= '0;
            char_q       <= '0;
            last_idx_q   <= '0;
            par_en_q     <= 1'b0;
            par_bit_q    <= 1'b0;
            stop_last_q  <= '0;
            tx_q         <= 1'b1;
            tx_busy_q    <= 1'b0;
            tx_done_q    <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            count_q      <= count_d;
            txrdy_q      <= (count_d != CW'(FIFO_DEPTH));
            fifo_empty_q <= (count_d == '0);
            overflow_q   <= wr_en && full;
            state_q      <= state_d;
            tick_q       <= tick_d;
            bit_idx_q    <= bit_idx_d;
            char_q       <= char_d;
            last_idx_q   <= last_idx_d;
            par_en_q     <= par_en_d;
            par_bit_q    <= par_bit_d;
            stop_last_q  <= stop_last_d;
            tx_q         <= tx_d;
            tx_busy_q    <= (state_d != StIdle);
            tx_done_q    <= done_d;
        end
    end

    assign tx         = tx_q;
    assign txrdy      = txrdy_q;
    assign fifo_empty = fifo_empty_q;
    assign fifo_count = count_q;
    assign tx_busy    = tx_busy_q;
    assign tx_done    = tx_done_q;
    assign overflow   = overflow_q;

endmodule
